tm1638_key_scanner: RTL and testbench
=====================================

# tm1638_key_scanner

Periodic key-scan sequencer for the TM1638 front-panel interface. Drives the STB/CLK/DIO pins, shifts out the read-key command 0x42, and drives `TM1368_receiver` over four byte reads via `rx_start`, `clk_fall` and `clk_rise`. Decodes the 32 received bits into an 8-bit key vector for the synthesizer control logic. Sits directly upstream of the receiver and also consumes its `rdata`.

## Interface
- `CLK_DIV`, 8: mclk cycles per serial-clock half period (8 gives 1 MHz at 16 MHz mclk); minimum 2.
- `T_WAIT`, 32: mclk cycles, DIO released, between the last command bit and the first read bit (≥1 µs TM1638 Twait).
- `SCAN_PERIOD`, 160000: mclk cycles between scan starts (10 ms).

Ports:
- `mclk` in 1: master 16 MHz clock; the only clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `scan_en` in 1: enables periodic scanning.
- `stb_o` out 1: TM1638 STB, active-low chip select.
- `clk_o` out 1: TM1638 CLK, idles high.
- `dio_out` out 1: DIO output value.
- `dio_oe` out 1: DIO output enable; 0 releases the pin.
- `clk_fall` out 1: one-mclk strobe that ends each read bit; feeds the receiver.
- `clk_rise` out 1: one-mclk strobe that marks the read sample point; feeds the receiver.
- `rx_start` out 1: one-mclk strobe that starts a receiver byte.
- `rdata` in 8: byte from the receiver.
- `keys` out 8: debounced-by-scan key state; bit k = key S(k+1).
- `keys_valid` out 1: one-mclk pulse when `keys` updates.
- `busy` out 1: high while a scan is in progress.

## Operation
- Reset values: `stb_o`=1, `clk_o`=1, `dio_out`=0, `dio_oe`=0, `clk_fall`/`clk_rise`/`rx_start`/`keys_valid`=0, `keys`=0, `busy`=0.
- Period counter runs only while `scan_en`=1 and is cleared while `scan_en`=0. A scan starts when it reaches `SCAN_PERIOD-1`; the counter then wraps to 0.
- Dropping `scan_en` mid-scan does not abort the scan; it completes and reports.
- FSM states: IDLE → SETUP → CMD → WAIT → RD_BIT → RD_END → (RD_BIT for next byte | FINISH) → IDLE.
  - **SETUP**: `stb_o`=0 for one half period.
  - **CMD**: 8 bits of 0x42, LSB first. Each bit: `clk_o` low with `dio_out`=bit and `dio_oe`=1 for one half, then `clk_o` high for one half. No receiver strobes are issued.
  - **WAIT**: `dio_oe`=0 and `clk_o`=1 for `T_WAIT` cycles.
  - **RD_BIT**: 8 bits per byte; `clk_o` low half, then high half.
    - `rx_start` pulses in the cycle of the pin falling edge of bit 0.
    - `clk_rise` pulses in the cycle of each pin rising edge.
    - `clk_fall` pulses in the cycle of the pin falling edge of bits 1–7. It does not pulse at bit 0.
  - **RD_END**: one half period with `clk_o` high. `clk_fall` pulses in its first cycle, terminating the receiver's bit 7. `rdata` is captured into byte slot b (0..3) in its last cycle.
  - **FINISH**: `stb_o`=1. `keys[b]` = byte b bit 0 and `keys[b+4]` = byte b bit 4, for b = 0..3. `keys_valid` pulses in the same cycle. Return to IDLE.
- `busy` is 1 from SETUP through FINISH inclusive.
- Asynchronous reset mid-scan: all outputs return to reset values immediately; `keys` is cleared and no `keys_valid` pulse is produced.

## Timing
- Half-period divider: a counter counts 0..`CLK_DIV-1`; pin edges occur on the cycle it reads 0.
- Strobes are registered and coincide exactly with the `clk_o` transition cycle.
- Scan length in mclk cycles: `CLK_DIV`·(1 + 16 + 4·17) + `T_WAIT` + 1 = 85·`CLK_DIV` + `T_WAIT` + 1. With defaults this is 713 cycles.
- `keys_valid` asserts on the last cycle of the scan.
- `SCAN_PERIOD` must be ≥ scan length. A start request that arrives while `busy`=1 is dropped, and the counter still wraps.

## Structure
- Shared package `tm1638_pkg`:
  - command constants `TM1638_CMD_READ_KEYS`=8'h42, `TM1638_CMD_WRITE_AUTO`=8'h40;
  - FSM state encoding;
  - key bit mapping constants (`KEY_LO_BIT`=0, `KEY_HI_BIT`=4).
- One natural sub-module, `tm1638_clk_gen`: the half-period divider producing `half_tick`, the `clk_o` level, and the raw rise/fall events.
- The FSM, byte/bit counters and key decode are in the top level.

## Test plan
- Reset with `scan_en`=0 for 1000 cycles: `stb_o`=1, `clk_o`=1, `dio_oe`=0, no strobes, `busy`=0.
- `scan_en`=1, `SCAN_PERIOD`=1000, and a TM1638 model returning bytes 0x01, 0x10, 0x00, 0x11:
  - DIO command bits read 0,1,0,0,0,0,1,0 on the first 8 `clk_o` rises;
  - `keys`=8'hA9 with one `keys_valid` pulse at cycle 713 after scan start.
- Strobe audit per byte: exactly one `rx_start`, 8 `clk_rise` and 8 `clk_fall`; no `clk_fall` before the first `clk_rise`. Over a full scan: 4 `rx_start`, 32 `clk_rise`, 32 `clk_fall`.
- Drop `scan_en` at cycle 300 of a scan: the scan completes and `keys_valid` pulses. No further scan starts within 3×`SCAN_PERIOD`.
- Assert `rst_n`=0 during the second read byte:
  - outputs return to reset values in the same cycle;
  - after release with `scan_en`=1, the next scan starts at count `SCAN_PERIOD-1`.
- All keys pressed (all bytes 0x11) gives `keys`=8'hFF. All bytes 0xEE gives `keys`=8'h00, because non-key bits are ignored.

Source files
------------

// File: rtl/tm1638_pkg.sv
// Shared TM1638 definitions: command bytes, key-scan FSM encoding and key bit
// positions within each byte returned by the read-keys command.
package tm1638_pkg;

    localparam logic [7:0] TM1638_CMD_READ_KEYS  = 8'h42;
    localparam logic [7:0] TM1638_CMD_WRITE_AUTO = 8'h40;

    // Each read byte carries two keys: one at bit 0 and one at bit 4.
    localparam int unsigned KEY_LO_BIT = 0;
    localparam int unsigned KEY_HI_BIT = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_CMD    = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RD_BIT = 3'd4,
        ST_RD_END = 3'd5,
        ST_FINISH = 3'd6
    } scan_state_t;

    // Byte b supplies keys[b] (lo) and keys[b+4] (hi).
    function automatic logic [7:0] decode_keys(input logic [3:0] lo, input logic [3:0] hi);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/tm1638_clk_gen.sv
// Serial-clock generator for the TM1638 link.
//   mclk, rst_n  : master clock, async active-low reset
//   run          : divider counts while high, held at 0 otherwise
//   clk_low      : requested clk_o level for the next cycle (1 = low)
//   half_tick_c  : last mclk cycle of the current half period
//   clk_o        : registered TM1638 CLK pin, idles high
//   rise_c/fall_c: clk_o will rise/fall at the next mclk edge
module tm1638_clk_gen #(
    parameter int unsigned CLK_DIV = 8
) (
    input  logic mclk,
    input  logic rst_n,
    input  logic run,
    input  logic clk_low,
    output logic half_tick_c,
    output logic clk_o,
    output logic rise_c,
    output logic fall_c
);

    localparam int unsigned     DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    assign half_tick_c = run && (div_cnt == DIV_LAST);
    assign rise_c      = !clk_o && !clk_low;
    assign fall_c      = clk_o && clk_low;

    // Half-period divider: restarts at 0 on every half and whenever idle.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (!run || half_tick_c) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Pin level register; changes only on the first cycle of a half.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            clk_o <= 1'b1;
        end else begin
            clk_o <= !clk_low;
        end
    end

endmodule

// File: rtl/tm1638_key_scanner.sv
// Periodic TM1638 key scanner: sends read-keys (0x42), sequences four byte
// reads through an external receiver and decodes the 8-key vector.
//   mclk, rst_n            : master clock, async active-low reset
//   scan_en                : enables the periodic scan timer
//   stb_o, clk_o           : TM1638 STB (active low) and CLK (idles high)
//   dio_out, dio_oe        : DIO value and output enable (0 releases the pin)
//   rx_start, clk_rise,
//   clk_fall               : receiver control strobes, one mclk each
//   rdata                  : byte assembled by the receiver
//   keys, keys_valid       : decoded keys and one-cycle update pulse
//   busy                   : scan in progress
module tm1638_key_scanner
    import tm1638_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 8,
    parameter int unsigned T_WAIT      = 32,
    parameter int unsigned SCAN_PERIOD = 160000
) (
    input  logic       mclk,
    input  logic       rst_n,
    input  logic       scan_en,
    output logic       stb_o,
    output logic       clk_o,
    output logic       dio_out,
    output logic       dio_oe,
    output logic       clk_fall,
    output logic       clk_rise,
    output logic       rx_start,
    input  logic [7:0] rdata,
    output logic [7:0] keys,
    output logic       keys_valid,
    output logic       busy
);

    localparam int unsigned       WAIT_W    = $clog2(T_WAIT + 1);
    localparam int unsigned       PER_W     = $clog2(SCAN_PERIOD + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(T_WAIT - 1);
    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(SCAN_PERIOD - 1);

    scan_state_t       state, state_nxt;
    logic [2:0]        bit_cnt, bit_nxt;
    logic [1:0]        byte_cnt, byte_nxt;
    logic              phase, phase_nxt;   // 0 = clk low half, 1 = clk high half
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic [PER_W-1:0]  per_cnt;
    logic [3:0]        key_lo, key_hi, lo_nxt, hi_nxt;

    logic run_c, start_c, clk_low_c, half_tick_c, rise_c, fall_c;
    logic stb_nxt, dio_out_nxt, dio_oe_nxt, busy_nxt, keys_valid_nxt;
    logic rx_start_nxt, clk_rise_nxt, clk_fall_nxt;

    // Only the two key bits of each byte carry information.
    logic unused_rdata;
    assign unused_rdata = ^{rdata[7:5], rdata[3:1]};

    assign run_c   = state inside {ST_SETUP, ST_CMD, ST_RD_BIT, ST_RD_END};
    assign start_c = scan_en && (per_cnt == PER_LAST) && (state == ST_IDLE);

    tm1638_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .mclk        (mclk),
        .rst_n       (rst_n),
        .run         (run_c),
        .clk_low     (clk_low_c),
        .half_tick_c (half_tick_c),
        .clk_o       (clk_o),
        .rise_c      (rise_c),
        .fall_c      (fall_c)
    );

    // Scan period timer; a start that lands while busy is simply lost.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt <= '0;
        end else if (!scan_en || per_cnt == PER_LAST) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + PER_W'(1);
        end
    end

    // FSM and sequencing registers.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            phase    <= 1'b0;
            wait_cnt <= '0;
            key_lo   <= '0;
            key_hi   <= '0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_nxt;
            byte_cnt <= byte_nxt;
            phase    <= phase_nxt;
            wait_cnt <= wait_nxt;
            key_lo   <= lo_nxt;
            key_hi   <= hi_nxt;
        end
    end

    // Next-state logic; each bit is a low half followed by a high half.
    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt;
        byte_nxt  = byte_cnt;
        phase_nxt = phase;
        wait_nxt  = wait_cnt;
        lo_nxt    = key_lo;
        hi_nxt    = key_hi;
        case (state)
            ST_IDLE: begin
                if (start_c) state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                if (half_tick_c) begin
                    state_nxt = ST_CMD;
                    bit_nxt   = '0;
                    phase_nxt = 1'b0;
                end
            end
            ST_CMD: begin
                if (half_tick_c) begin
                    phase_nxt = !phase;
                    if (phase) begin
                        if (bit_cnt == 3'd7) begin
                            state_nxt = ST_WAIT;
                            wait_nxt  = '0;
                        end else begin
                            bit_nxt = bit_cnt + 3'd1;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_nxt = ST_RD_BIT;
                    bit_nxt   = '0;
                    byte_nxt  = '0;
                    phase_nxt = 1'b0;
                end else begin
                    wait_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            ST_RD_BIT: begin
                if (half_tick_c) begin
                    phase_nxt = !phase;
                    if (phase) begin
                        if (bit_cnt == 3'd7) begin
                            state_nxt = ST_RD_END;
                        end else begin
                            bit_nxt = bit_cnt + 3'd1;
                        end
                    end
                end
            end
            ST_RD_END: begin
                // Receiver byte is complete by the last cycle of this half.
                if (half_tick_c) begin
                    lo_nxt[byte_cnt] = rdata[KEY_LO_BIT];
                    hi_nxt[byte_cnt] = rdata[KEY_HI_BIT];
                    phase_nxt        = 1'b0;
                    if (byte_cnt == 2'd3) begin
                        state_nxt = ST_FINISH;
                    end else begin
                        state_nxt = ST_RD_BIT;
                        byte_nxt  = byte_cnt + 2'd1;
                        bit_nxt   = '0;
                    end
                end
            end
            ST_FINISH: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        clk_low_c = (state_nxt == ST_CMD || state_nxt == ST_RD_BIT) && !phase_nxt;
    end

    // Output decode from the next state so every output is a flop.
    always_comb begin
        busy_nxt       = (state_nxt != ST_IDLE);
        stb_nxt        = !(busy_nxt && state_nxt != ST_FINISH);
        dio_oe_nxt     = (state_nxt == ST_CMD);
        dio_out_nxt    = dio_oe_nxt && TM1638_CMD_READ_KEYS[bit_nxt];
        rx_start_nxt   = fall_c && (state_nxt == ST_RD_BIT) && (bit_nxt == 3'd0);
        clk_rise_nxt   = rise_c && (state_nxt == ST_RD_BIT);
        // Bit 7 is closed by a pseudo-fall on entry to RD_END (pin stays high).
        clk_fall_nxt   = (fall_c && (state_nxt == ST_RD_BIT) && (bit_nxt != 3'd0))
                       || (state == ST_RD_BIT && state_nxt == ST_RD_END);
        keys_valid_nxt = (state_nxt == ST_FINISH);
    end

    // Registered outputs.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            stb_o      <= 1'b1;
            dio_out    <= 1'b0;
            dio_oe     <= 1'b0;
            rx_start   <= 1'b0;
            clk_rise   <= 1'b0;
            clk_fall   <= 1'b0;
            busy       <= 1'b0;
            keys_valid <= 1'b0;
            keys       <= '0;
        end else begin
            stb_o      <= stb_nxt;
            dio_out    <= dio_out_nxt;
            dio_oe     <= dio_oe_nxt;
            rx_start   <= rx_start_nxt;
            clk_rise   <= clk_rise_nxt;
            clk_fall   <= clk_fall_nxt;
            busy       <= busy_nxt;
            keys_valid <= keys_valid_nxt;
            if (keys_valid_nxt) begin
                keys <= decode_keys(lo_nxt, hi_nxt);
            end
        end
    end

endmodule

// File: tb/tb_tm1638_key_scanner.sv
// Bench for tm1638_key_scanner: a receiver/TM1638 model answers reads, the
// stimulus pushes the expected key vector per scan and a monitor pops and
// checks it on each keys_valid together with timing and strobe audits.
module tb_tm1638_key_scanner;

    localparam int CLK_DIV     = 8;
    localparam int T_WAIT      = 32;
    localparam int SCAN_PERIOD = 1000;
    localparam int SCAN_LEN    = 85 * CLK_DIV + T_WAIT + 1;

    logic       mclk    = 1'b0;
    logic       rst_n   = 1'b0;
    logic       scan_en = 1'b0;
    logic       stb_o, clk_o, dio_out, dio_oe, clk_fall, clk_rise, rx_start;
    logic       keys_valid, busy;
    logic [7:0] keys;
    logic [7:0] rdata_m = 8'h00;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    logic [7:0] tm_bytes[4];

    tm1638_key_scanner #(
        .CLK_DIV(CLK_DIV), .T_WAIT(T_WAIT), .SCAN_PERIOD(SCAN_PERIOD)
    ) dut (
        .mclk(mclk), .rst_n(rst_n), .scan_en(scan_en),
        .stb_o(stb_o), .clk_o(clk_o), .dio_out(dio_out), .dio_oe(dio_oe),
        .clk_fall(clk_fall), .clk_rise(clk_rise), .rx_start(rx_start),
        .rdata(rdata_m), .keys(keys), .keys_valid(keys_valid), .busy(busy)
    );

    always #5 mclk = ~mclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // Reference: key S(b+1) is bit 0 of byte b, key S(b+5) is bit 4 of byte b.
    function automatic logic [7:0] ref_keys(input logic [31:0] w);
        logic [7:0] r;
        r = 8'h00;
        for (int b = 0; b < 4; b++) begin
            r[b]     = w[8*b];
            r[b + 4] = w[8*b + 4];
        end
        return r;
    endfunction

    task automatic load_scan(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        tm_bytes[0] = b0;
        tm_bytes[1] = b1;
        tm_bytes[2] = b2;
        tm_bytes[3] = b3;
        exp_q.push_back(ref_keys({b3, b2, b1, b0}));
    endtask

    // Receiver + TM1638: shifts the chip's byte LSB first on each clk_rise.
    logic [2:0] rx_n = 3'd0;
    logic [2:0] pos  = 3'd0;
    logic [1:0] byte_sel;
    assign byte_sel = 2'(rx_n - 3'd1);

    always @(posedge mclk) begin
        if (!rst_n || !busy) begin
            rx_n <= 3'd0;
        end else if (rx_start) begin
            rx_n    <= rx_n + 3'd1;
            pos     <= 3'd0;
            rdata_m <= 8'h00;
        end else if (clk_rise && rx_n != 3'd0) begin
            rdata_m <= {tm_bytes[byte_sel][pos], rdata_m[7:1]};
            pos     <= pos + 3'd1;
        end
    end

    // Monitor
    int         cyc = 0, start_cyc = 0, rxc = 0, clk_rises = 0, stray = 0;
    int         order_err = 0, cmd_oe_err = 0, ok_bytes = 0, rise_tot = 0, fall_tot = 0;
    int         br[4], bf[4];
    logic [7:0] cmd_cap = 8'h00;
    logic [7:0] exp_k;
    logic       busy_q = 1'b0, clk_q = 1'b1;

    always @(negedge mclk) begin
        cyc++;
        if (!rst_n) begin
            busy_q = 1'b0;
            clk_q  = 1'b1;
            rxc    = 0;
        end else begin
            if (busy && !busy_q) begin
                start_cyc  = cyc;
                rxc        = 0;
                clk_rises  = 0;
                cmd_cap    = 8'h00;
                order_err  = 0;
                cmd_oe_err = 0;
                for (int i = 0; i < 4; i++) begin
                    br[i] = 0;
                    bf[i] = 0;
                end
            end
            if (!busy && (rx_start || clk_rise || clk_fall || keys_valid)) stray++;
            if (busy && clk_o && !clk_q) begin
                if (clk_rises < 8) begin
                    cmd_cap[clk_rises] = dio_out;
                    if (!dio_oe) cmd_oe_err++;
                end
                clk_rises++;
            end
            if (rx_start) rxc++;
            if (clk_rise) begin
                if (rxc >= 1 && rxc <= 4) br[rxc-1]++;
                else order_err++;
            end
            if (clk_fall) begin
                if (rxc >= 1 && rxc <= 4) begin
                    if (br[rxc-1] == 0) order_err++;
                    bf[rxc-1]++;
                end else begin
                    order_err++;
                end
            end
            if (keys_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_keys_valid", 1, 0);
                end else begin
                    exp_k = exp_q.pop_front();
                    chk("keys", 32'(keys), 32'(exp_k));
                end
                ok_bytes = 0;
                rise_tot = 0;
                fall_tot = 0;
                for (int i = 0; i < 4; i++) begin
                    if (br[i] == 8 && bf[i] == 8) ok_bytes++;
                    rise_tot += br[i];
                    fall_tot += bf[i];
                end
                chk("kv_latency", 32'(cyc - start_cyc), 32'(SCAN_LEN - 1));
                chk("rx_start_count", 32'(rxc), 32'd4);
                chk("clk_rise_total", 32'(rise_tot), 32'd32);
                chk("clk_fall_total", 32'(fall_tot), 32'd32);
                chk("bytes_with_8_rise_8_fall", 32'(ok_bytes), 32'd4);
                chk("strobe_order_errors", 32'(order_err), 32'd0);
                chk("cmd_byte", 32'(cmd_cap), 32'h42);
                chk("cmd_dio_oe_errors", 32'(cmd_oe_err), 32'd0);
            end
            busy_q = busy;
            clk_q  = clk_o;
        end
    end

    task automatic wait_busy(output int n);
        n = 0;
        do begin
            @(negedge mclk);
            n++;
        end while (!busy && n < 5 * SCAN_PERIOD);
    endtask

    task automatic wait_kv(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge mclk);
            n++;
        end while (!keys_valid && n < 3 * SCAN_PERIOD);
        if (!keys_valid) chk({tag, "_kv_timeout"}, 0, 1);
    endtask

    // Stimulus
    initial begin
        int n, viol, nb, rxs;
        tm_bytes[0] = 8'h00;
        tm_bytes[1] = 8'h00;
        tm_bytes[2] = 8'h00;
        tm_bytes[3] = 8'h00;
        repeat (5) @(negedge mclk);
        chk("rst_stb_o", 32'(stb_o), 1);
        chk("rst_clk_o", 32'(clk_o), 1);
        chk("rst_dio", 32'({dio_out, dio_oe}), 0);
        chk("rst_strobes", 32'({rx_start, clk_rise, clk_fall, keys_valid}), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_keys", 32'(keys), 0);
        rst_n = 1'b1;

        viol = 0;
        repeat (1000) begin
            @(negedge mclk);
            if (stb_o !== 1'b1 || clk_o !== 1'b1 || dio_oe !== 1'b0 || busy !== 1'b0 ||
                {rx_start, clk_rise, clk_fall, keys_valid} !== 4'b0) viol++;
        end
        chk("idle_disabled_violations", 32'(viol), 0);

        load_scan(8'h01, 8'h10, 8'h00, 8'h11);
        scan_en = 1'b1;
        wait_busy(n);
        chk("first_start_latency", 32'(n), 32'(SCAN_PERIOD));
        wait_kv("scan_a9");

        for (int i = 0; i < 6; i++) begin
            case (i)
                0:       load_scan(8'h11, 8'h11, 8'h11, 8'h11);
                1:       load_scan(8'hEE, 8'hEE, 8'hEE, 8'hEE);
                default: load_scan(8'($urandom()), 8'($urandom()), 8'($urandom()), 8'($urandom()));
            endcase
            wait_busy(n);
            chk("scan_gap", 32'(n), 32'(SCAN_PERIOD - SCAN_LEN + 1));
            wait_kv("scan_loop");
        end

        // Drop scan_en mid-scan: scan still completes, then no new scans.
        load_scan(8'h11, 8'h01, 8'h10, 8'h00);
        wait_busy(n);
        repeat (300) @(negedge mclk);
        scan_en = 1'b0;
        wait_kv("scan_drop");
        nb = 0;
        repeat (3 * SCAN_PERIOD) begin
            @(negedge mclk);
            if (busy) nb++;
        end
        chk("no_scan_while_disabled", 32'(nb), 0);

        // Async reset during the second read byte.
        load_scan(8'($urandom()), 8'($urandom()), 8'($urandom()), 8'($urandom()));
        scan_en = 1'b1;
        wait_busy(n);
        chk("reenable_start_latency", 32'(n), 32'(SCAN_PERIOD));
        rxs = 0;
        n   = 0;
        while (rxs < 2 && n < 2000) begin
            @(negedge mclk);
            n++;
            if (rx_start) rxs++;
        end
        chk("second_byte_reached", 32'(rxs), 2);
        repeat (12) @(negedge mclk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_stb_o", 32'(stb_o), 1);
        chk("abort_clk_o", 32'(clk_o), 1);
        chk("abort_dio", 32'({dio_out, dio_oe}), 0);
        chk("abort_strobes", 32'({rx_start, clk_rise, clk_fall, keys_valid}), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_keys", 32'(keys), 0);
        void'(exp_q.pop_back());
        load_scan(8'h11, 8'h10, 8'h01, 8'hEE);
        repeat (5) @(negedge mclk);
        rst_n = 1'b1;
        wait_busy(n);
        chk("post_reset_start_latency", 32'(n), 32'(SCAN_PERIOD));
        wait_kv("scan_post_reset");

        repeat (10) @(negedge mclk);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        chk("stray_strobes", 32'(stray), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
